// File: rtl/pwm_multi_pkg.sv
// Register map, control bit positions and byte-lane helpers shared by the
// pwm_multi top level and its channel slices.
package pwm_multi_pkg;

   localparam int unsigned REG_CTRL  = 'h00;
   localparam int unsigned REG_DT    = 'h01;
   localparam int unsigned REG_PRD   = 'h02;
   localparam int unsigned CH_BASE   = 'h08;
   localparam int unsigned CH_STRIDE = 8;
   localparam int unsigned CMPH_OFF  = 0;
   localparam int unsigned CMPL_OFF  = 4;
   localparam int unsigned REG_BYTES = 3;

   localparam int unsigned CTRL_EN   = 0;
   localparam int unsigned CTRL_LOAD = 1;

   function automatic int unsigned min_adr_w(input int unsigned nch);
      return $clog2(CH_BASE + CH_STRIDE * nch);
   endfunction

   function automatic logic [7:0] get_byte(input logic [23:0] v, input logic [1:0] k);
      case (k)
         2'd0:    return v[7:0];
         2'd1:    return v[15:8];
         2'd2:    return v[23:16];
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [23:0] set_byte(input logic [23:0] v, input logic [1:0] k,
                                            input logic [7:0] b);
      logic [23:0] r;
      r = v;
      case (k)
         2'd0:    r[7:0]   = b;
         2'd1:    r[15:8]  = b;
         2'd2:    r[23:16] = b;
         default: r        = v;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/pwm_multi_chan.sv
// One I/Q channel: compare window against the shared timebase, raw-edge
// detection, dead-time insertion and the registered output pair.
module pwm_chan
   import pwm_multi_pkg::*;
#(
   parameter int unsigned WIDTH = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [WIDTH-1:0] tb_i,
   input  logic [WIDTH-1:0] cmph_i,
   input  logic [WIDTH-1:0] cmpl_i,
   input  logic [7:0]       dt_i,
   output logic             pwm_i_o,
   output logic             pwm_q_o
);

   logic       raw_d, raw_q;
   logic [7:0] cnt_d, cnt_q;
   logic       pi_d, pi_q;
   logic       pq_d, pq_q;

   // An empty or inverted window (cmpl >= cmph) falls out of the compare as constant 0.
   always_comb begin
      raw_d = (cmpl_i <= tb_i) && (tb_i < cmph_i);
      cnt_d = '0;
      if (raw_d != raw_q) begin
         cnt_d = dt_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 8'd1;
      end
      pi_d = en_i && (cnt_d == '0) && raw_d;
      pq_d = en_i && (cnt_d == '0) && !raw_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         raw_q <= 1'b0;
         cnt_q <= '0;
         pi_q  <= 1'b0;
         pq_q  <= 1'b0;
      end else begin
         raw_q <= raw_d;
         cnt_q <= cnt_d;
         pi_q  <= pi_d;
         pq_q  <= pq_d;
      end
   end

   assign pwm_i_o = pi_q;
   assign pwm_q_o = pq_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel I/Q PWM: shared down-counting timebase, shadow/active register
// banks behind a byte-wide Wishbone slave, one pwm_chan per channel.
module pwm_multi
   import pwm_multi_pkg::*;
#(
   parameter int unsigned WIDTH   = 18,
   parameter int unsigned NCH     = 2,
   parameter int unsigned PRD_RST = 8,
   parameter int unsigned ADR_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wb_cyc_i,
   input  logic             wb_stb_i,
   input  logic             wb_we_i,
   input  logic [ADR_W-1:0] wb_adr_i,
   input  logic [7:0]       wb_dat_i,
   output logic [7:0]       wb_dat_o,
   output logic             wb_ack_o,
   output logic [NCH-1:0]   pwm_i,
   output logic [NCH-1:0]   pwm_q
);

   logic             en_q, ack_q;
   logic [7:0]       dat_q, rdata;
   logic [7:0]       dt_s_q, dt_a_q;
   logic [WIDTH-1:0] prd_s_q, prd_a_q;
   logic [WIDTH-1:0] tb_q, tb_d;
   logic [WIDTH-1:0] cmph_s_q [NCH];
   logic [WIDTH-1:0] cmpl_s_q [NCH];
   logic [WIDTH-1:0] cmph_a_q [NCH];
   logic [WIDTH-1:0] cmpl_a_q [NCH];

   logic             req, wr, load, xfer;
   logic             sel_ctrl, sel_dt, sel_prd;
   logic [NCH-1:0]   sel_cmph, sel_cmpl;
   logic [1:0]       bsel;
   logic [23:0]      old24, new24;
   logic [31:0]      adr;

   assign req  = wb_cyc_i & wb_stb_i & ~ack_q;
   assign wr   = wb_cyc_i & wb_stb_i & wb_we_i & ack_q;
   assign load = wr & sel_ctrl & wb_dat_i[CTRL_LOAD];
   assign xfer = (tb_q == '0) | load;

   // One shared 24-bit view of the addressed multi-byte register serves both
   // the read mux and the byte merge for writes.
   always_comb begin
      adr      = 32'(wb_adr_i);
      sel_ctrl = (adr == REG_CTRL);
      sel_dt   = (adr == REG_DT);
      sel_prd  = (adr >= REG_PRD) && (adr < REG_PRD + REG_BYTES);
      bsel     = sel_prd ? 2'(adr - REG_PRD) : 2'(adr % 4);
      sel_cmph = '0;
      sel_cmpl = '0;
      old24    = '0;
      if (sel_prd) old24 = 24'(prd_s_q);
      for (int unsigned n = 0; n < NCH; n++) begin
         sel_cmph[n] = (adr >= CH_BASE + n * CH_STRIDE + CMPH_OFF) &&
                       (adr <  CH_BASE + n * CH_STRIDE + CMPH_OFF + REG_BYTES);
         sel_cmpl[n] = (adr >= CH_BASE + n * CH_STRIDE + CMPL_OFF) &&
                       (adr <  CH_BASE + n * CH_STRIDE + CMPL_OFF + REG_BYTES);
         if (sel_cmph[n]) old24 = 24'(cmph_s_q[n]);
         if (sel_cmpl[n]) old24 = 24'(cmpl_s_q[n]);
      end
      new24 = set_byte(old24, bsel, wb_dat_i);
      rdata = get_byte(old24, bsel);
      if (sel_ctrl) rdata = 8'(en_q);
      if (sel_dt)   rdata = dt_s_q;
   end

   always_comb begin
      tb_d = '0;
      if (en_q) begin
         tb_d = (tb_q == '0) ? prd_a_q : tb_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q   <= 1'b0;
         dat_q   <= '0;
         en_q    <= 1'b1;
         dt_s_q  <= '0;
         prd_s_q <= WIDTH'(PRD_RST);
         for (int unsigned n = 0; n < NCH; n++) begin
            cmph_s_q[n] <= '0;
            cmpl_s_q[n] <= '0;
         end
      end else begin
         ack_q <= req;
         dat_q <= (req && !wb_we_i) ? rdata : '0;
         if (wr) begin
            if (sel_ctrl) en_q    <= wb_dat_i[CTRL_EN];
            if (sel_dt)   dt_s_q  <= wb_dat_i;
            if (sel_prd)  prd_s_q <= new24[WIDTH-1:0];
            for (int unsigned n = 0; n < NCH; n++) begin
               if (sel_cmph[n]) cmph_s_q[n] <= new24[WIDTH-1:0];
               if (sel_cmpl[n]) cmpl_s_q[n] <= new24[WIDTH-1:0];
            end
         end
      end
   end

   // EN=0 pins tb at 0, so the boundary term alone keeps the active bank tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tb_q    <= '0;
         prd_a_q <= WIDTH'(PRD_RST);
         dt_a_q  <= '0;
         for (int unsigned n = 0; n < NCH; n++) begin
            cmph_a_q[n] <= '0;
            cmpl_a_q[n] <= '0;
         end
      end else begin
         tb_q <= tb_d;
         if (xfer) begin
            prd_a_q <= prd_s_q;
            dt_a_q  <= dt_s_q;
            for (int unsigned n = 0; n < NCH; n++) begin
               cmph_a_q[n] <= cmph_s_q[n];
               cmpl_a_q[n] <= cmpl_s_q[n];
            end
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      pwm_chan #(
         .WIDTH(WIDTH)
      ) u_chan (
         .clk    (clk),
         .rst    (rst),
         .en_i   (en_q),
         .tb_i   (tb_q),
         .cmph_i (cmph_a_q[g]),
         .cmpl_i (cmpl_a_q[g]),
         .dt_i   (dt_a_q),
         .pwm_i_o(pwm_i[g]),
         .pwm_q_o(pwm_q[g])
      );
   end

   assign wb_dat_o = dat_q;
   assign wb_ack_o = ack_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: timebase, windows, dead-time, shadow updates,
// enable handling and Wishbone register access.
module tb_pwm_multi;

   logic       clk = 1'b0;
   logic       rst;
   logic       wb_cyc_i, wb_stb_i, wb_we_i;
   logic [7:0] wb_adr_i;
   logic [7:0] wb_dat_i;
   logic [7:0] wb_dat_o;
   logic       wb_ack_o;
   logic [1:0] pwm_i, pwm_q;

   int n_checks = 0;
   int n_fail   = 0;
   int n_i, n_q, n_both, n_none;

   pwm_multi #(
      .WIDTH  (18),
      .NCH    (2),
      .PRD_RST(8),
      .ADR_W  (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .wb_cyc_i(wb_cyc_i),
      .wb_stb_i(wb_stb_i),
      .wb_we_i (wb_we_i),
      .wb_adr_i(wb_adr_i),
      .wb_dat_i(wb_dat_i),
      .wb_dat_o(wb_dat_o),
      .wb_ack_o(wb_ack_o),
      .pwm_i   (pwm_i),
      .pwm_q   (pwm_q)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wb_write(input logic [7:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = a;    wb_dat_i = d;
      @(posedge clk); #1;
      check_eq("wr_ack", wb_ack_o, 1);
      @(posedge clk); #1;
      check_eq("wr_ack_drop", wb_ack_o, 0);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
   endtask

   task automatic wb_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
      @(posedge clk); #1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
      wb_adr_i = a;
      @(posedge clk); #1;
      check_eq("rd_ack", wb_ack_o, 1);
      check_eq(tag, wb_dat_o, exp);
      @(posedge clk); #1;
      check_eq("rd_ack_drop", wb_ack_o, 0);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
   endtask

   task automatic measure(input int unsigned ch, input int unsigned ncyc);
      n_i = 0; n_q = 0; n_both = 0; n_none = 0;
      for (int unsigned k = 0; k < ncyc; k++) begin
         @(negedge clk);
         if (pwm_i[ch]) n_i++;
         if (pwm_q[ch]) n_q++;
         if (pwm_i[ch] && pwm_q[ch]) n_both++;
         if (!pwm_i[ch] && !pwm_q[ch]) n_none++;
      end
   endtask

   task automatic wait_tb(input int unsigned val);
      bit found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (dut.tb_q == 18'(val)) found = 1'b1;
      end
      check_eq("wait_tb", found, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned prev_tb;
      int          cnt;
      bit          found;

      rst = 1'b1;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      wb_adr_i = '0;   wb_dat_i = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state, then free-running timebase with default PRD=8
      @(negedge clk);
      check_eq("rst_tb", dut.tb_q, 0);
      check_eq("rst_pwm_i", pwm_i, 0);
      check_eq("rst_pwm_q", pwm_q, 0);
      check_eq("rst_ack", wb_ack_o, 0);
      check_eq("rst_dat", wb_dat_o, 0);
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         check_eq("tb_seq", dut.tb_q, 8 - (k % 9));
         check_eq("idle_pwm_i", pwm_i, 2'b00);
         check_eq("idle_pwm_q", pwm_q, 2'b11);
      end

      // Basic window: PRD=9, [2,6), DT=0
      wb_write(8'h02, 8'd9);
      wb_write(8'h03, 8'd0);
      wb_write(8'h04, 8'd0);
      wb_write(8'h0C, 8'd2);
      wb_write(8'h08, 8'd6);
      wb_write(8'h01, 8'd0);
      wb_write(8'h00, 8'h03);
      repeat (25) @(negedge clk);
      measure(0, 10);
      check_eq("basic_i_hi", n_i, 4);
      check_eq("basic_q_hi", n_q, 6);
      check_eq("basic_both", n_both, 0);
      check_eq("basic_gap", n_none, 0);
      measure(1, 10);
      check_eq("ch1_i_hi", n_i, 0);
      check_eq("ch1_q_hi", n_q, 10);
      @(negedge clk);
      prev_tb = dut.tb_q;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check_eq("phase_i0", pwm_i[0], (prev_tb >= 2 && prev_tb < 6));
         check_eq("phase_q0", pwm_q[0], !(prev_tb >= 2 && prev_tb < 6));
         prev_tb = dut.tb_q;
      end

      // Dead-time of one cycle
      wb_write(8'h01, 8'd1);
      wb_write(8'h00, 8'h03);
      repeat (25) @(negedge clk);
      measure(0, 10);
      check_eq("dt_i_hi", n_i, 3);
      check_eq("dt_q_hi", n_q, 5);
      check_eq("dt_both", n_both, 0);
      check_eq("dt_gap", n_none, 2);

      // Glitch-free compare update
      wb_write(8'h01, 8'd0);
      wb_write(8'h00, 8'h03);
      repeat (25) @(negedge clk);
      wait_tb(9);
      wb_write(8'h08, 8'd8);
      cnt = 0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (pwm_i[0]) cnt++;
         if (dut.tb_q == 18'd9) found = 1'b1;
      end
      check_eq("upd_boundary", found, 1);
      check_eq("upd_old_width", cnt, 4);
      measure(0, 10);
      check_eq("upd_new_i_hi", n_i, 6);
      check_eq("upd_new_q_hi", n_q, 4);

      // Degenerate window on channel 1, then disable/enable
      wb_write(8'h14, 8'd5);
      wb_write(8'h10, 8'd5);
      wb_write(8'h00, 8'h03);
      repeat (12) @(negedge clk);
      measure(1, 10);
      check_eq("degen_i_hi", n_i, 0);
      check_eq("degen_q_hi", n_q, 10);
      wb_write(8'h00, 8'h00);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         check_eq("dis_pwm_i", pwm_i, 0);
         check_eq("dis_pwm_q", pwm_q, 0);
         check_eq("dis_tb", dut.tb_q, 0);
      end
      wb_write(8'h00, 8'h01);
      check_eq("en_tb_start", dut.tb_q, 0);
      @(posedge clk); #1;
      check_eq("en_tb_reload", dut.tb_q, 9);

      // Register access, masking and unmapped addresses
      wb_write(8'h02, 8'hFF);
      wb_write(8'h03, 8'hFF);
      wb_write(8'h04, 8'hFF);
      wb_read(8'h02, 8'hFF, "prd_b0");
      wb_read(8'h03, 8'hFF, "prd_b1");
      wb_read(8'h04, 8'h03, "prd_b2_mask");
      wb_read(8'h00, 8'h01, "ctrl_rd");
      wb_read(8'h01, 8'h00, "dt_rd");
      wb_read(8'h05, 8'h00, "unmapped_rd");
      wb_read(8'h08, 8'h08, "cmph0_rd");
      wb_read(8'h0C, 8'h02, "cmpl0_rd");
      wb_read(8'h14, 8'h05, "cmpl1_rd");
      wb_write(8'h18, 8'hAA);
      wb_read(8'h18, 8'h00, "unmapped_wr");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
